// File: rtl/parallel_to_serial_rf.sv
// Register-file serializer: captures one packed word of N_ELEMS elements and
// emits it one element per accepted beat, element 0 (LSBs) first.
module parallel_to_serial_rf #(
  parameter int WIDTH   = 1,
  parameter int N_ELEMS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH*N_ELEMS-1:0]   in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out,
  output logic [31:0]                out_idx,
  output logic                       out_last
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                     state;
  logic [WIDTH*N_ELEMS-1:0]   data;
  logic [31:0]                idx;
  logic                       load;
  logic                       send;

  assign out_valid = (state == SEND);
  assign out_idx   = idx;
  assign out_last  = out_valid & (idx == 32'(N_ELEMS - 1));
  assign out       = out_valid ? data[WIDTH*idx +: WIDTH] : '0;

  // Accepting a new word on the final beat of the current one avoids a bubble.
  assign in_ready  = (state == IDLE) | (send & out_last);
  assign load      = in_valid & in_ready;
  assign send      = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            data  <= in;
            idx   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (send) begin
            if (!out_last) begin
              idx <= idx + 32'd1;
            end else if (load) begin
              data <= in;
              idx  <= '0;
            end else begin
              idx   <= '0;
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_to_serial_rf.sv
// Directed self-checking bench for parallel_to_serial_rf: a WIDTH=8/N_ELEMS=4
// instance plus a WIDTH=4/N_ELEMS=1 instance sharing clock, reset and out_ready.
module tb_parallel_to_serial_rf;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_ready;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic [7:0]  out_elem;
  logic [31:0] out_idx;
  logic        out_last;

  logic        in_valid1;
  logic        in_ready1;
  logic [3:0]  in_word1;
  logic        out_valid1;
  logic [3:0]  out_elem1;
  logic [31:0] out_idx1;
  logic        out_last1;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [31:0] WORD_A = 32'h44332211;
  localparam logic [31:0] WORD_B = 32'h88776655;

  always #5 clk = ~clk;

  parallel_to_serial_rf #(.WIDTH(8), .N_ELEMS(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in(in_word),
    .out_valid(out_valid), .out_ready(out_ready), .out(out_elem),
    .out_idx(out_idx), .out_last(out_last)
  );

  parallel_to_serial_rf #(.WIDTH(4), .N_ELEMS(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in(in_word1),
    .out_valid(out_valid1), .out_ready(out_ready), .out(out_elem1),
    .out_idx(out_idx1), .out_last(out_last1)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are compared 1ns later,
  // so each call describes one cycle and the next edge captures it.
  task automatic applyStimulus(input logic r, input logic iv, input logic [31:0] din,
                               input logic ordy, input logic iv1, input logic [3:0] din1);
    @(posedge clk);
    #1;
    rst       = r;
    in_valid  = iv;
    in_word   = din;
    out_ready = ordy;
    in_valid1 = iv1;
    in_word1  = din1;
    #1;
  endtask

  task automatic checkBeat(input string tag, input logic ev, input logic [7:0] ed,
                           input int ei, input logic el, input logic eir);
    checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
    checkOutput({tag, ".out"},       64'(out_elem),  64'(ed));
    checkOutput({tag, ".out_idx"},   64'(out_idx),   64'(ei));
    checkOutput({tag, ".out_last"},  64'(out_last),  64'(el));
    checkOutput({tag, ".in_ready"},  64'(in_ready),  64'(eir));
  endtask

  task automatic checkBeat1(input string tag, input logic ev, input logic [3:0] ed,
                            input logic el, input logic eir);
    checkOutput({tag, ".out_valid"}, 64'(out_valid1), 64'(ev));
    checkOutput({tag, ".out"},       64'(out_elem1),  64'(ed));
    checkOutput({tag, ".out_idx"},   64'(out_idx1),   64'd0);
    checkOutput({tag, ".out_last"},  64'(out_last1),  64'(el));
    checkOutput({tag, ".in_ready"},  64'(in_ready1),  64'(eir));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_word = '0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_word1 = '0;

    // Reset state
    applyStimulus(1, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkBeat("reset", 0, 8'h00, 0, 0, 1);
    checkBeat1("reset1", 0, 4'h0, 0, 1);

    // Single word, consumer always ready
    applyStimulus(0, 1, WORD_A, 1, 0, 0); checkBeat("t1.load", 0, 8'h00, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);      checkBeat("t1.b0",   1, 8'h11, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);      checkBeat("t1.b1",   1, 8'h22, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);      checkBeat("t1.b2",   1, 8'h33, 2, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);      checkBeat("t1.b3",   1, 8'h44, 3, 1, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);      checkBeat("t1.idle", 0, 8'h00, 0, 0, 1);

    // Consumer stalls for two cycles on element 1
    applyStimulus(0, 1, WORD_A, 1, 0, 0); checkBeat("t2.load", 0, 8'h00, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);      checkBeat("t2.b0",   1, 8'h11, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);      checkBeat("t2.st0",  1, 8'h22, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);      checkBeat("t2.st1",  1, 8'h22, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);      checkBeat("t2.b1",   1, 8'h22, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);      checkBeat("t2.b2",   1, 8'h33, 2, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);      checkBeat("t2.b3",   1, 8'h44, 3, 1, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);      checkBeat("t2.idle", 0, 8'h00, 0, 0, 1);

    // Back-to-back words with in_valid held; second word taken on the 0x44 beat
    applyStimulus(0, 1, WORD_A, 1, 0, 0); checkBeat("t3.load", 0, 8'h00, 0, 0, 1);
    applyStimulus(0, 1, WORD_B, 1, 0, 0); checkBeat("t3.b0",   1, 8'h11, 0, 0, 0);
    applyStimulus(0, 1, WORD_B, 1, 0, 0); checkBeat("t3.b1",   1, 8'h22, 1, 0, 0);
    applyStimulus(0, 1, WORD_B, 1, 0, 0); checkBeat("t3.b2",   1, 8'h33, 2, 0, 0);
    applyStimulus(0, 1, WORD_B, 1, 0, 0); checkBeat("t3.b3",   1, 8'h44, 3, 1, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);      checkBeat("t3.b4",   1, 8'h55, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);      checkBeat("t3.b5",   1, 8'h66, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);      checkBeat("t3.b6",   1, 8'h77, 2, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);      checkBeat("t3.b7",   1, 8'h88, 3, 1, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);      checkBeat("t3.idle", 0, 8'h00, 0, 0, 1);

    // in_valid while in_ready is low must be ignored
    applyStimulus(0, 1, WORD_A, 1, 0, 0);       checkBeat("t4.load", 0, 8'h00, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);            checkBeat("t4.b0",   1, 8'h11, 0, 0, 0);
    applyStimulus(0, 1, 32'hDEADBEEF, 1, 0, 0); checkBeat("t4.b1",   1, 8'h22, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);            checkBeat("t4.b2",   1, 8'h33, 2, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);            checkBeat("t4.b3",   1, 8'h44, 3, 1, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);            checkBeat("t4.idle", 0, 8'h00, 0, 0, 1);

    // Reset mid-word discards the rest; a new word restarts at element 0
    applyStimulus(0, 1, WORD_A, 1, 0, 0); checkBeat("t5.load", 0, 8'h00, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);      checkBeat("t5.b0",   1, 8'h11, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);      checkBeat("t5.b1",   1, 8'h22, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0);      checkBeat("t5.b2",   1, 8'h33, 2, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);      checkBeat("t5.rst",  0, 8'h00, 0, 0, 1);
    applyStimulus(0, 1, WORD_B, 1, 0, 0); checkBeat("t5.load2",0, 8'h00, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 0);      checkBeat("t5.n0",   1, 8'h55, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);      checkBeat("t5.n1",   1, 8'h66, 1, 0, 0);

    // N_ELEMS=1: every beat is last, idx stays 0
    applyStimulus(0, 0, 0, 1, 1, 4'h5); checkBeat1("t6.load", 0, 4'h0, 0, 1);
    applyStimulus(0, 0, 0, 1, 1, 4'hA); checkBeat1("t6.b0",   1, 4'h5, 1, 1);
    applyStimulus(0, 0, 0, 1, 0, 4'h0); checkBeat1("t6.b1",   1, 4'hA, 1, 1);
    applyStimulus(0, 0, 0, 1, 0, 4'h0); checkBeat1("t6.idle", 0, 4'h0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/parallel_to_serial_rf.md
Name: parallel_to_serial_rf

Overview:
- Register-file serializer, the transmit-side counterpart of the serial-to-parallel register file.
- Captures one packed word of N_ELEMS elements and emits it one element per accepted beat, element 0 first.
- Uses a valid/ready handshake on both sides.
- Sits between a wide producer (e.g. an SRAM row read) and a narrow per-element consumer pipeline.

Parameters:
WIDTH, 1, bits per element
N_ELEMS, 4, elements per packed word (>= 1)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset
in_valid  input  1  packed word on in is valid
in_ready  output  1  serializer can capture in this cycle
in  input  WIDTH*N_ELEMS  packed word; element i at bits [WIDTH*i +: WIDTH]
out_valid  output  1  out holds a valid element
out_ready  input  1  consumer accepts out this cycle
out  output  WIDTH  current element
out_idx  output  32  index of current element, 0..N_ELEMS-1
out_last  output  1  current element is index N_ELEMS-1

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- State: FSM {IDLE, SEND}, data register [WIDTH*N_ELEMS-1:0], idx counter (32 bit, 0..N_ELEMS-1).
- Reset (rst high at posedge), dominates everything:
  - state=IDLE, idx=0, data=0.
  - Outputs: out_valid=0, out=0, out_idx=0, out_last=0, in_ready=1.
  - A word in flight is discarded with no further beats. Applies mid-SEND too.
- load = in_valid & in_ready. send = out_valid & out_ready.
- Outputs:
  - out_valid = (state==SEND).
  - out = data[WIDTH*idx +: WIDTH] when out_valid, else 0.
  - out_idx = idx.
  - out_last = out_valid & (idx==N_ELEMS-1).
- in_ready (combinational) = (state==IDLE) | (send & out_last). This allows load-through with no bubble between words.
- IDLE:
  - On load: data<=in, idx<=0, state<=SEND.
  - in captured at edge k → first element valid in cycle k+1 (latency 1).
- SEND:
  - send & !out_last: idx<=idx+1.
  - send & out_last & load: data<=in, idx<=0, stay SEND (back-to-back words).
  - send & out_last & !load: idx<=0, state<=IDLE.
  - !send: hold data, idx, state. out stays stable while out_valid & !out_ready (no element dropped or skipped).
- in_valid while in_ready=0: ignored, no capture. The producer must hold the word.
- N_ELEMS=1: every beat has out_last=1, idx stays 0.
- Throughput: N_ELEMS beats per word at out_ready=1 continuously. Zero idle cycles between words when in_valid is held.
- Order matches the serial-to-parallel register file: element 0 (LSBs) first, so the two chained give identity.
- Handshake rule: out_ready may depend combinationally on out_valid; in_valid must not depend on in_ready.

Test Plan:
- WIDTH=8, N_ELEMS=4, reset then in=0x44332211 with in_valid for 1 cycle, out_ready=1 → in_ready=1 at load. Beats 0x11,0x22,0x33,0x44 on cycles k+1..k+4 with out_idx 0..3. out_last only on 0x44. Then IDLE, out_valid=0, out=0.
- Same word, out_ready low on the cycle showing 0x22 and on the next cycle → 0x22 held 3 cycles with out_idx=1. Sequence complete, no duplicate or skipped element.
- Back-to-back: words 0x44332211 then 0x88776655, in_valid held high → second word loaded on the 0x44 beat. 8 consecutive valid beats, no bubble. in_ready low on beats 0x11..0x33.
- in_valid pulsed with 0xDEADBEEF on the 0x22 beat (in_ready=0) → ignored; stream unchanged.
- rst asserted on the 0x33 beat → next cycle out_valid=0, out=0, out_idx=0, in_ready=1. A new word afterwards starts at element 0.
- N_ELEMS=1, WIDTH=4, words 0x5,0xA back-to-back → two beats, both out_last=1, out_idx=0, then IDLE.
